wb_writer: RTL
==============

// Module: wb_writer
// PURPOSE
//   Write-back writer for the 32x32 register bank (BR). Accepts retiring
//   instructions from the MEM stage over a valid/ready handshake. Selects the
//   write data (ALU result, memory data or PC+4) and the destination (rt, rd
//   or link register), buffers them in a 2-entry queue, and drives the bank
//   write port (RegWrite/WriteRegister/WriteData) under a grant handshake.
// PARAMETERS
//   DATA_W    32  width of write data
//   ADDR_W    5   register index width
//   LINK_REG  31  destination for reg_dst=2'b10 (jal)
// PORTS
//   clk            in   1       clock, rising edge
//   rst            in   1       reset, asynchronous, active-high
//   in_valid       in   1       MEM stage offers an instruction
//   in_ready       out  1       writer can accept this cycle
//   in_reg_write   in   1       instruction writes a register
//   in_reg_dst     in   2       00 rt, 01 rd, 10 LINK_REG, 11 rt
//   in_mem_to_reg  in   2       00 alu, 01 mem, 10 pc4, 11 alu
//   in_rt, in_rd   in   ADDR_W  candidate destinations
//   in_alu_res     in   DATA_W  ALU result
//   in_mem_data    in   DATA_W  load data
//   in_pc4         in   DATA_W  PC+4 (link value)
//   flush          in   1       discard all queued writes
//   wr_grant       in   1       bank accepts the presented write
//   RegWrite       out  1       write request to bank
//   WriteRegister  out  ADDR_W  destination index
//   WriteData      out  DATA_W  value to write
//   wb_count       out  16      committed writes, saturating
// BEHAVIOUR
//   - Reset (async, rst=1): queue emptied; RegWrite=0, WriteRegister=0,
//     WriteData=0, wb_count=0, in_ready=1 after release.
//   - Queue: 2 entries {dest, data}. in_ready = (occupancy < 2). It is a pure
//     function of registered occupancy (no path from wr_grant or in_valid).
//   - Accept: in_valid & in_ready at edge. Dest/data are muxed at accept time.
//     Entry is enqueued only if in_reg_write=1 and the muxed dest != 0;
//     otherwise the instruction is consumed silently (no write, no count).
//   - Head: RegWrite = occupancy>0. WriteRegister/WriteData = head entry,
//     0 when empty. Latency: accept at edge N -> RegWrite=1 in cycle after N
//     if the queue was empty.
//   - Commit: RegWrite & wr_grant at edge pops the head; wb_count += 1,
//     holding at 16'hFFFF. Outputs are held stable while RegWrite=1 and
//     wr_grant=0.
//   - Simultaneous push+pop: allowed when occupancy is 1 (occupancy stays 1,
//     FIFO order kept). At occupancy 2, no push (in_ready=0); a pop frees a
//     slot for the next cycle.
//   - flush: synchronous, priority over push and pop. Queue is emptied and
//     nothing is committed or counted that edge. An in_valid beat that edge
//     is dropped.
//   - rst asserted mid-operation: queued writes are lost immediately and
//     RegWrite drops asynchronously.
// CONFIGURATION
//   WB_FWD_EN defined: adds inputs fwd_ar1, fwd_ar2 [ADDR_W] and outputs
//     fwd_hit1, fwd_hit2 [1] and fwd_data1, fwd_data2 [DATA_W]. These are
//     combinational. hitN=1 when a queued entry's dest == fwd_arN (and != 0);
//     the youngest matching entry supplies fwd_dataN. With no hit, data=0.
//   WB_FWD_EN undefined: these ports and logic do not exist.
// TESTING
//   1 rst=1 mid-run with 2 entries queued -> RegWrite=0 at once;
//     wb_count=0; in_ready=1 after release.
//   2 reg_dst=01 rd=5, mem_to_reg=00 alu=32'h1234, wr_grant=1 -> next cycle
//     RegWrite=1, WR=5, WD=32'h1234; popped; wb_count=1.
//   3 reg_dst=10 mem_to_reg=10 pc4=32'h0040_0008 -> WR=31, WD=32'h0040_0008.
//   4 dest rt=0 or reg_write=0 -> accepted, RegWrite stays 0, wb_count
//     unchanged.
//   5 wr_grant=0, push 3 back-to-back -> in_ready=0 after 2. Grant 3 cycles
//     -> writes in order A,B,C; wb_count=3.
//   6 2 queued + flush=1 with in_valid=1 -> queue empty, RegWrite=0, count
//     unchanged. With WB_FWD_EN: entries r7=1 then r7=2 queued, fwd_ar1=7 ->
//     fwd_hit1=1, fwd_data1=2.

Source files
------------

// File: rtl/wb_writer.sv
// Write-back writer: muxes retiring results into a 2-entry queue and drains it into the register bank.
// Optional macro WB_FWD_EN adds combinational forwarding lookups into the queued writes.
module wb_writer #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_reg_write,
  input  logic [1:0]        in_reg_dst,
  input  logic [1:0]        in_mem_to_reg,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_pc4,
  input  logic              flush,
  input  logic              wr_grant,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
`ifdef WB_FWD_EN
  input  logic [ADDR_W-1:0] fwd_ar1,
  input  logic [ADDR_W-1:0] fwd_ar2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DATA_W-1:0] fwd_data1,
  output logic [DATA_W-1:0] fwd_data2,
`endif
  output logic [15:0]       wb_count
);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [ADDR_W-1:0] q_dest_p1 [2];
  logic [DATA_W-1:0] q_data_p1 [2];
  logic              rd_ptr_p1, wr_ptr_p1;
  logic [1:0]        occ_p1;
  logic [15:0]       cnt_p1;

  logic [ADDR_W-1:0] sel_dest_p0;
  logic [DATA_W-1:0] sel_data_p0;
  logic              push_p0, pop_p0;

  // Stage p0: select destination and data of the offered instruction
  always_comb begin
    sel_dest_p0 = in_rt;
    sel_data_p0 = in_alu_res;
    case (in_reg_dst)
      2'b01:   sel_dest_p0 = in_rd;
      2'b10:   sel_dest_p0 = ADDR_W'(LINK_REG);
      default: sel_dest_p0 = in_rt;
    endcase
    case (in_mem_to_reg)
      2'b01:   sel_data_p0 = in_mem_data;
      2'b10:   sel_data_p0 = in_pc4;
      default: sel_data_p0 = in_alu_res;
    endcase
  end

  // Writes to r0 or with reg_write=0 are consumed without occupying a slot.
  assign in_ready = (occ_p1 != 2'd2);
  assign push_p0  = in_valid & in_ready & in_reg_write & (sel_dest_p0 != '0) & ~flush;
  assign pop_p0   = RegWrite & wr_grant & ~flush;

  // Stage p1: queue control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_p1 <= 1'b0;
      wr_ptr_p1 <= 1'b0;
      occ_p1    <= 2'd0;
      cnt_p1    <= 16'd0;
    end else if (flush) begin
      rd_ptr_p1 <= 1'b0;
      wr_ptr_p1 <= 1'b0;
      occ_p1    <= 2'd0;
    end else begin
      if (push_p0) wr_ptr_p1 <= ~wr_ptr_p1;
      if (pop_p0) begin
        rd_ptr_p1 <= ~rd_ptr_p1;
        cnt_p1    <= sat_inc16(cnt_p1);
      end
      case ({push_p0, pop_p0})
        2'b10:   occ_p1 <= occ_p1 + 2'd1;
        2'b01:   occ_p1 <= occ_p1 - 2'd1;
        default: occ_p1 <= occ_p1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_p0) begin
      q_dest_p1[wr_ptr_p1] <= sel_dest_p0;
      q_data_p1[wr_ptr_p1] <= sel_data_p0;
    end
  end

  assign RegWrite      = (occ_p1 != 2'd0);
  assign WriteRegister = RegWrite ? q_dest_p1[rd_ptr_p1] : '0;
  assign WriteData     = RegWrite ? q_data_p1[rd_ptr_p1] : '0;
  assign wb_count      = cnt_p1;

`ifdef WB_FWD_EN
  // Returns {hit, data}; the younger slot is only live when two entries are queued.
  function automatic logic [DATA_W:0] fwd_lookup(
    input logic [ADDR_W-1:0] ar,
    input logic [1:0]        occ,
    input logic [ADDR_W-1:0] d_old,
    input logic [DATA_W-1:0] v_old,
    input logic [ADDR_W-1:0] d_young,
    input logic [DATA_W-1:0] v_young
  );
    logic [DATA_W:0] r;
    r = '0;
    if (ar != '0) begin
      if (occ != 2'd0 && d_old == ar)   r = {1'b1, v_old};
      if (occ == 2'd2 && d_young == ar) r = {1'b1, v_young};
    end
    return r;
  endfunction

  always_comb begin
    {fwd_hit1, fwd_data1} = fwd_lookup(fwd_ar1, occ_p1,
      q_dest_p1[rd_ptr_p1], q_data_p1[rd_ptr_p1],
      q_dest_p1[rd_ptr_p1 ^ 1'b1], q_data_p1[rd_ptr_p1 ^ 1'b1]);
    {fwd_hit2, fwd_data2} = fwd_lookup(fwd_ar2, occ_p1,
      q_dest_p1[rd_ptr_p1], q_data_p1[rd_ptr_p1],
      q_dest_p1[rd_ptr_p1 ^ 1'b1], q_data_p1[rd_ptr_p1 ^ 1'b1]);
  end
`endif

endmodule
